cgb_pixel_mixer: RTL and testbench



---
 rtl/cgb_pixel_mixer.sv | 177 +++++++++++++++++
 tb/tb_cgb_pixel_mixer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cgb_pixel_mixer.sv
// CGB per-pixel BG/sprite mixer: priority arbitration, palette lookup, BGR555->RGB888,
// X tracking and a small output FIFO with valid/ready toward the LCD writer.
module cgb_pixel_mixer #(
   parameter int LINE_WIDTH = 160,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_PIX_VALID,
   output logic        O_PIX_READY,
   input  logic [2:0]  I_BG_PAL,
   input  logic [1:0]  I_BG_IDX,
   input  logic        I_BG_PRIO,
   input  logic        I_SPR_VALID,
   input  logic [2:0]  I_SPR_PAL,
   input  logic [1:0]  I_SPR_IDX,
   input  logic        I_SPR_BEHIND,
   input  logic        I_MASTER_PRIO,
   input  logic        I_LINE_START,
   output logic [2:0]  O_BGPAL_SEL,
   output logic [1:0]  O_BGPAL_INDEX,
   output logic [2:0]  O_SPRPAL_SEL,
   output logic [1:0]  O_SPRPAL_INDEX,
   input  logic [15:0] I_BGPAL_COLOR,
   input  logic [15:0] I_SPRPAL_COLOR,
   output logic        O_PIX_VALID,
   input  logic        I_PIX_READY,
   output logic [23:0] O_PIX_RGB,
   output logic [7:0]  O_PIX_X,
   output logic        O_PIX_LINE_END
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0] X_LAST = 8'(LINE_WIDTH - 1);

   // Colour file word has the even byte on top; swap back before splitting the fields.
   function automatic logic [23:0] bgr555_to_rgb888(input logic [15:0] raw);
      logic [4:0] r5;
      logic [4:0] g5;
      logic [4:0] b5;
      r5 = raw[12:8];
      g5 = {raw[1:0], raw[15:13]};
      b5 = raw[6:2];
      return {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
   endfunction

   logic          s1_valid_r;
   logic [2:0]    s1_bg_pal_r;
   logic [1:0]    s1_bg_idx_r;
   logic          s1_bg_prio_r;
   logic          s1_spr_valid_r;
   logic [2:0]    s1_spr_pal_r;
   logic [1:0]    s1_spr_idx_r;
   logic          s1_spr_behind_r;
   logic [7:0]    s1_x_r;
   logic          s1_line_end_r;
   logic [7:0]    x_r;

   logic [23:0]   fifo_rgb_r [FIFO_DEPTH];
   logic [7:0]    fifo_x_r   [FIFO_DEPTH];
   logic          fifo_le_r  [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;

   logic          accept_s;
   logic          push_s;
   logic          pop_s;
   logic          spr_win_s;
   logic [23:0]   rgb_s;
   logic [7:0]    px_s;
   logic [AW+1:0] occupancy_s;

   assign occupancy_s = {1'b0, count_r} + {{(AW+1){1'b0}}, s1_valid_r};
   assign O_PIX_READY = (occupancy_s < (AW+2)'(FIFO_DEPTH));
   assign accept_s    = I_PIX_VALID && O_PIX_READY;
   assign push_s      = s1_valid_r;
   assign pop_s       = (count_r != '0) && I_PIX_READY;

   assign O_BGPAL_SEL    = s1_bg_pal_r;
   assign O_BGPAL_INDEX  = s1_bg_idx_r;
   assign O_SPRPAL_SEL   = s1_spr_pal_r;
   assign O_SPRPAL_INDEX = s1_spr_idx_r;

   assign O_PIX_VALID    = (count_r != '0);
   assign O_PIX_RGB      = fifo_rgb_r[rd_ptr_r];
   assign O_PIX_X        = fifo_x_r[rd_ptr_r];
   assign O_PIX_LINE_END = fifo_le_r[rd_ptr_r];

   // X of the pixel being accepted; a line-start pulse forces it to column 0.
   always_comb begin
      px_s = x_r;
      if (I_LINE_START) begin
         px_s = 8'd0;
      end else begin
         px_s = x_r;
      end
   end

   // BG/sprite arbitration and colour conversion for the pixel held in S1.
   always_comb begin
      spr_win_s = s1_spr_valid_r && (s1_spr_idx_r != 2'd0) &&
                  (!I_MASTER_PRIO || (s1_bg_idx_r == 2'd0) || (!s1_bg_prio_r && !s1_spr_behind_r));
      rgb_s = 24'd0;
      if (spr_win_s) begin
         rgb_s = bgr555_to_rgb888(I_SPRPAL_COLOR);
      end else begin
         rgb_s = bgr555_to_rgb888(I_BGPAL_COLOR);
      end
   end

   // Input stage S1 and the scanline X counter.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         s1_valid_r      <= 1'b0;
         s1_bg_pal_r     <= 3'd0;
         s1_bg_idx_r     <= 2'd0;
         s1_bg_prio_r    <= 1'b0;
         s1_spr_valid_r  <= 1'b0;
         s1_spr_pal_r    <= 3'd0;
         s1_spr_idx_r    <= 2'd0;
         s1_spr_behind_r <= 1'b0;
         s1_x_r          <= 8'd0;
         s1_line_end_r   <= 1'b0;
         x_r             <= 8'd0;
      end else if (accept_s) begin
         s1_valid_r      <= 1'b1;
         s1_bg_pal_r     <= I_BG_PAL;
         s1_bg_idx_r     <= I_BG_IDX;
         s1_bg_prio_r    <= I_BG_PRIO;
         s1_spr_valid_r  <= I_SPR_VALID;
         s1_spr_pal_r    <= I_SPR_PAL;
         s1_spr_idx_r    <= I_SPR_IDX;
         s1_spr_behind_r <= I_SPR_BEHIND;
         s1_x_r          <= px_s;
         s1_line_end_r   <= (px_s == X_LAST);
         x_r             <= (px_s == X_LAST) ? 8'd0 : px_s + 8'd1;
      end else begin
         s1_valid_r <= 1'b0;
         if (I_LINE_START) begin
            x_r <= 8'd0;
         end else begin
            x_r <= x_r;
         end
      end
   end

   // Output FIFO: circular buffer; S1 always has a free slot thanks to the ready rule.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_rgb_r[i] <= 24'd0;
            fifo_x_r[i]   <= 8'd0;
            fifo_le_r[i]  <= 1'b0;
         end
      end else begin
         if (push_s) begin
            fifo_rgb_r[wr_ptr_r] <= rgb_s;
            fifo_x_r[wr_ptr_r]   <= s1_x_r;
            fifo_le_r[wr_ptr_r]  <= s1_line_end_r;
            wr_ptr_r             <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_cgb_pixel_mixer.sv
// Self-checking bench for cgb_pixel_mixer: priority/colour vector table plus
// backpressure, line-wrap, line-start, reset and streaming sequences.
module tb_cgb_pixel_mixer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [2:0]  bg_pal;
   logic [1:0]  bg_idx;
   logic        bg_prio;
   logic        spr_valid;
   logic [2:0]  spr_pal;
   logic [1:0]  spr_idx;
   logic        spr_behind;
   logic        master;
   logic        line_start;
   logic [2:0]  bgpal_sel, sprpal_sel;
   logic [1:0]  bgpal_index, sprpal_index;
   logic [15:0] bg_color, spr_color;
   logic        out_valid, out_ready;
   logic [23:0] out_rgb;
   logic [7:0]  out_x;
   logic        out_le;

   int n_checks = 0;
   int n_pass   = 0;

   cgb_pixel_mixer dut (
      .I_CLK(clk), .I_RESET(rst),
      .I_PIX_VALID(in_valid), .O_PIX_READY(in_ready),
      .I_BG_PAL(bg_pal), .I_BG_IDX(bg_idx), .I_BG_PRIO(bg_prio),
      .I_SPR_VALID(spr_valid), .I_SPR_PAL(spr_pal), .I_SPR_IDX(spr_idx), .I_SPR_BEHIND(spr_behind),
      .I_MASTER_PRIO(master), .I_LINE_START(line_start),
      .O_BGPAL_SEL(bgpal_sel), .O_BGPAL_INDEX(bgpal_index),
      .O_SPRPAL_SEL(sprpal_sel), .O_SPRPAL_INDEX(sprpal_index),
      .I_BGPAL_COLOR(bg_color), .I_SPRPAL_COLOR(spr_color),
      .O_PIX_VALID(out_valid), .I_PIX_READY(out_ready),
      .O_PIX_RGB(out_rgb), .O_PIX_X(out_x), .O_PIX_LINE_END(out_le)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  bg_pal;
      logic [1:0]  bg_idx;
      logic        bg_prio;
      logic        spr_valid;
      logic [2:0]  spr_pal;
      logic [1:0]  spr_idx;
      logic        spr_behind;
      logic        master;
      logic [15:0] bg_color;
      logic [15:0] spr_color;
      logic [23:0] exp_rgb;
   } vec_t;

   vec_t vecs[10];

   int q_x[$];
   int q_le[$];
   int q_lat_bad;
   int acc_edge[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; line_start = 1'b0;
      step(); step();
      rst = 1'b0;
   endtask

   // Streams n pixels with downstream always ready; records head X/line_end and latency.
   task automatic run_stream(input int n, input int ls_at);
      int acc;
      int oi;
      acc = 0; oi = 0;
      q_x.delete(); q_le.delete(); acc_edge.delete(); q_lat_bad = 0;
      out_ready = 1'b1;
      for (int c = 0; c < n + 10; c++) begin
         in_valid   = (acc < n);
         line_start = (acc == ls_at) && (acc < n);
         if (out_valid) begin
            q_x.push_back(int'(out_x));
            q_le.push_back(int'(out_le));
            if (oi >= acc_edge.size() || (c - acc_edge[oi]) != 1) q_lat_bad++;
            oi++;
         end
         if (in_valid && in_ready) begin
            acc_edge.push_back(c + 1);
            acc++;
         end
         step();
      end
      in_valid = 1'b0; line_start = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      int accepts;
      int idx;
      //            bgpal idx prio sv  spal sidx beh mst  bgcol     sprcol    exp
      vecs[0] = '{3'd1, 2'd1, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1, 16'h56B5, 16'h1F00, 24'hB5526B};
      vecs[1] = '{3'd3, 2'd2, 1'b0, 1'b1, 3'd5, 2'd3, 1'b0, 1'b1, 16'h56B5, 16'h1F00, 24'hFF0000};
      vecs[2] = '{3'd3, 2'd2, 1'b0, 1'b1, 3'd5, 2'd3, 1'b1, 1'b1, 16'h56B5, 16'h1F00, 24'hB5526B};
      vecs[3] = '{3'd3, 2'd2, 1'b0, 1'b1, 3'd5, 2'd3, 1'b1, 1'b0, 16'h56B5, 16'h1F00, 24'hFF0000};
      vecs[4] = '{3'd3, 2'd2, 1'b0, 1'b1, 3'd5, 2'd0, 1'b1, 1'b0, 16'h56B5, 16'h1F00, 24'hB5526B};
      vecs[5] = '{3'd7, 2'd0, 1'b1, 1'b1, 3'd6, 2'd2, 1'b1, 1'b1, 16'h56B5, 16'h1F00, 24'hFF0000};
      vecs[6] = '{3'd4, 2'd1, 1'b1, 1'b1, 3'd1, 2'd1, 1'b0, 1'b1, 16'h56B5, 16'h1F00, 24'hB5526B};
      vecs[7] = '{3'd2, 2'd3, 1'b0, 1'b0, 3'd7, 2'd3, 1'b0, 1'b0, 16'h56B5, 16'h1F00, 24'hB5526B};
      vecs[8] = '{3'd0, 2'd1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 16'h00FF, 16'h1F00, 24'h00C6FF};
      vecs[9] = '{3'd5, 2'd1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 16'hFF7F, 16'h1F00, 24'hFFFFFF};

      bg_pal = 3'd0; bg_idx = 2'd0; bg_prio = 1'b0; spr_valid = 1'b0; spr_pal = 3'd0;
      spr_idx = 2'd0; spr_behind = 1'b0; master = 1'b1; bg_color = 16'h0000; spr_color = 16'h0000;
      do_reset();

      check("reset_ready", 32'(in_ready), 32'd1);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_rgb", 32'(out_rgb), 32'd0);
      check("reset_x", 32'(out_x), 32'd0);
      check("reset_le", 32'(out_le), 32'd0);
      check("reset_lookup", 32'({bgpal_sel, bgpal_index, sprpal_sel, sprpal_index}), 32'd0);

      for (int i = 0; i < 10; i++) begin
         bg_pal = vecs[i].bg_pal; bg_idx = vecs[i].bg_idx; bg_prio = vecs[i].bg_prio;
         spr_valid = vecs[i].spr_valid; spr_pal = vecs[i].spr_pal; spr_idx = vecs[i].spr_idx;
         spr_behind = vecs[i].spr_behind; master = vecs[i].master;
         bg_color = vecs[i].bg_color; spr_color = vecs[i].spr_color;
         in_valid = 1'b1;
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_lookup", i), 32'({bgpal_sel, bgpal_index, sprpal_sel, sprpal_index}),
               32'({vecs[i].bg_pal, vecs[i].bg_idx, vecs[i].spr_pal, vecs[i].spr_idx}));
         check($sformatf("vec%0d_early_valid", i), 32'(out_valid), 32'd0);
         step();
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_rgb", i), 32'(out_rgb), 32'(vecs[i].exp_rgb));
         check($sformatf("vec%0d_x", i), 32'(out_x), 32'(i));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
      end
      check("lookup_hold", 32'({bgpal_sel, sprpal_sel}), 32'({3'd5, 3'd0}));

      // Backpressure with downstream stalled.
      bg_color = 16'h56B5; spr_valid = 1'b0;
      do_reset();
      accepts = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (in_ready) accepts++;
         step();
      end
      check("bp_accepts", 32'(accepts), 32'd4);
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_head_x", 32'(out_x), 32'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      accepts = 0;
      for (int c = 0; c < 6; c++) begin
         if (in_ready) accepts++;
         step();
      end
      in_valid = 1'b0;
      check("bp_one_more", 32'(accepts), 32'd1);
      check("bp_ready_low2", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) begin
            idx++;
            check($sformatf("bp_order%0d", idx), 32'(out_x), 32'(idx));
         end
         step();
      end
      out_ready = 1'b0;
      check("bp_drain_count", 32'(idx), 32'd4);

      // Line wrap over 161 pixels.
      do_reset();
      run_stream(161, -1);
      check("wrap_count", 32'(q_x.size()), 32'd161);
      if (q_x.size() == 161) begin
         check("wrap_x158_le", 32'(q_le[158]), 32'd0);
         check("wrap_x159", 32'(q_x[159]), 32'd159);
         check("wrap_x159_le", 32'(q_le[159]), 32'd1);
         check("wrap_x160", 32'(q_x[160]), 32'd0);
         check("wrap_x160_le", 32'(q_le[160]), 32'd0);
      end
      check("wrap_latency", 32'(q_lat_bad), 32'd0);

      // Line start coinciding with accept of pixel 50.
      do_reset();
      run_stream(60, 50);
      check("ls_count", 32'(q_x.size()), 32'd60);
      if (q_x.size() == 60) begin
         check("ls_x49", 32'(q_x[49]), 32'd49);
         check("ls_x50", 32'(q_x[50]), 32'd0);
         check("ls_x51", 32'(q_x[51]), 32'd1);
      end

      // Reset with three pixels in the FIFO and S1 full.
      do_reset();
      in_valid = 1'b1;
      step(); step(); step(); step();
      in_valid = 1'b0;
      check("mid_full_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      step();
      check("mid_rst_no_stale", 32'(out_valid), 32'd0);
      run_stream(1, -1);
      check("mid_rst_count", 32'(q_x.size()), 32'd1);
      if (q_x.size() == 1) check("mid_rst_x", 32'(q_x[0]), 32'd0);

      // Streaming 20 pixels with downstream always ready.
      do_reset();
      run_stream(20, -1);
      check("stream_count", 32'(q_x.size()), 32'd20);
      check("stream_latency", 32'(q_lat_bad), 32'd0);
      idx = 0;
      for (int i = 0; i < q_x.size(); i++) if (q_x[i] != i) idx++;
      check("stream_order", 32'(idx), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
